// File: rtl/io_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_pkg
//  Description : Shared types and constants for the half-duplex I/O bus
//                direction scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_bus_pkg;

    // Default width of the shared off-chip data bus
    localparam int IO_DATA_W = 8;

    // Values driven onto IO_Bus.mode_sel
    localparam logic MODE_TX = 1'b0;    // pins driven by us
    localparam logic MODE_RX = 1'b1;    // pins hi-Z / receiving

    // Scheduler states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TURN_TX = 3'd1,
        TX      = 3'd2,
        TURN_RX = 3'd3,
        RX      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/io_bus_turn_timer.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_turn_timer
//  Description : Loadable down-counter timing the hi-Z turnaround gaps.
//                done_o is high once the count has reached zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bus_turn_timer
    import io_bus_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load on entry to a turnaround state, otherwise count down and hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/io_bus_sched.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_sched
//  Description : Half-duplex direction scheduler for the shared off-chip bus.
//                Arbitrates TX bursts against RX capture windows and inserts
//                hi-Z turnaround gaps so both ends never drive together.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bus_sched
    import io_bus_pkg::*;
#(
    parameter int DATA_W    = IO_DATA_W,
    parameter int TURN_CYC  = 2,
    parameter int MAX_BURST = 16,
    parameter int RX_LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [DATA_W-1:0]   tx_sample,
    input  logic                rx_req,
    input  logic [RX_LEN_W-1:0] rx_len,
    output logic                rx_busy,
    output logic                rx_valid,
    output logic [DATA_W-1:0]   rx_data,
    output logic                rx_done,
    output logic                mode_sel,
    output logic [DATA_W-1:0]   bus_tx_data,
    input  logic [DATA_W-1:0]   bus_rx_data
);

    localparam int c_turn_w  = $clog2(TURN_CYC + 1);
    localparam int c_burst_w = $clog2(MAX_BURST + 1);
    // The timer holds the gap's first cycle at load, so load one less than the gap
    localparam logic [c_turn_w-1:0]  c_turn_load = c_turn_w'(TURN_CYC - 1);
    localparam logic [c_burst_w-1:0] c_max_burst = c_burst_w'(MAX_BURST);
    localparam logic [RX_LEN_W-1:0]  c_rx_last   = RX_LEN_W'(1);

    state_t                state_q, state_d;
    logic [c_burst_w-1:0]  burst_q, burst_d;
    logic [RX_LEN_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [RX_LEN_W-1:0]   rx_len_q, rx_len_d;
    logic                  rx_pend_q, rx_pend_d;
    logic [DATA_W-1:0]     tx_data_q, tx_data_d;
    logic [DATA_W-1:0]     rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_done_q, rx_done_d;

    logic                  turn_load;
    logic                  turn_done;
    logic                  tx_hs;
    logic                  req_acc;
    logic                  pend_now;
    logic [RX_LEN_W-1:0]   len_now;

    io_bus_turn_timer #(
        .CNT_W (c_turn_w)
    ) u_turn_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (turn_load),
        .load_val_i (c_turn_load),
        .done_o     (turn_done)
    );

    assign tx_ready    = (state_q == TX) && (burst_q < c_max_burst);
    assign tx_hs       = tx_valid && tx_ready;
    assign rx_busy     = rx_pend_q || (state_q == TURN_RX) || (state_q == RX);
    // A request seen this cycle counts immediately so IDLE can start RX next cycle
    assign req_acc     = rx_req && !rx_busy;
    assign pend_now    = rx_pend_q || req_acc;
    assign len_now     = rx_pend_q ? rx_len_q : rx_len;
    assign mode_sel    = (state_q == TX) ? MODE_TX : MODE_RX;
    assign bus_tx_data = tx_data_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_done     = rx_done_q;

    // Next-state, request latching and datapath updates
    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        rx_cnt_d   = rx_cnt_q;
        rx_len_d   = rx_len_q;
        rx_pend_d  = rx_pend_q;
        tx_data_d  = '0;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_done_d  = 1'b0;
        turn_load  = 1'b0;

        if (req_acc) begin
            rx_pend_d = 1'b1;
            rx_len_d  = rx_len;
        end

        case (state_q)
            IDLE: begin
                if (pend_now) begin
                    // Pins are already hi-Z, no gap needed before capturing
                    state_d   = RX;
                    rx_cnt_d  = len_now;
                    rx_pend_d = 1'b0;
                end else if (tx_valid) begin
                    state_d   = TURN_TX;
                    turn_load = 1'b1;
                end
            end
            TURN_TX: begin
                if (turn_done) begin
                    state_d = TX;
                    burst_d = '0;
                end
            end
            TX: begin
                tx_data_d = tx_data_q;
                if (tx_hs) begin
                    tx_data_d = tx_sample;
                    burst_d   = burst_q + 1'b1;
                end else if (pend_now) begin
                    state_d   = TURN_RX;
                    turn_load = 1'b1;
                    tx_data_d = '0;
                end else if ((burst_q == c_max_burst) && tx_valid) begin
                    // One-cycle bubble at the burst boundary, then keep going
                    burst_d = '0;
                end else begin
                    state_d   = IDLE;
                    tx_data_d = '0;
                end
            end
            TURN_RX: begin
                if (turn_done) begin
                    state_d   = RX;
                    rx_cnt_d  = rx_len_q;
                    rx_pend_d = 1'b0;
                end
            end
            RX: begin
                if (rx_cnt_q == '0) begin
                    rx_done_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    rx_data_d  = bus_rx_data;
                    rx_valid_d = 1'b1;
                    rx_cnt_d   = rx_cnt_q - 1'b1;
                    if (rx_cnt_q == c_rx_last) begin
                        rx_done_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset releases the pins immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            burst_q    <= '0;
            rx_cnt_q   <= '0;
            rx_len_q   <= '0;
            rx_pend_q  <= 1'b0;
            tx_data_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_len_q   <= rx_len_d;
            rx_pend_q  <= rx_pend_d;
            tx_data_q  <= tx_data_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_done_q  <= rx_done_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/io_bus_sched.md
# io_bus_sched

Half-duplex direction scheduler for the shared 8-bit off-chip bus. It sits between the modulator (TX stream), the demodulator (RX capture windows) and `IO_Bus`, and owns that wrapper's `mode_sel` (0 = drive, 1 = hi-Z/receive) and `tx_data`. It arbitrates TX bursts against RX window requests and inserts turnaround gaps so the pins are never driven by both ends. It delivers captured RX samples to the demod with a valid strobe.

## Interface
- `DATA_W`, 8, bus width.
- `TURN_CYC`, 2, hi-Z turnaround cycles inserted before driving and after releasing the bus (≥1).
- `MAX_BURST`, 16, maximum TX beats per burst before RX may pre-empt (≥1).
- `RX_LEN_W`, 8, width of the RX window length.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `tx_valid`  in  1  modulator has a sample.
- `tx_ready`  out  1  sample accepted when `tx_valid & tx_ready`.
- `tx_sample`  in  DATA_W  modulator sample.
- `rx_req`  in  1  one-cycle request for an RX window.
- `rx_len`  in  RX_LEN_W  window length in samples, sampled with `rx_req`.
- `rx_busy`  out  1  RX request pending or in progress.
- `rx_valid`  out  1  `rx_data` holds a captured sample.
- `rx_data`  out  DATA_W  captured sample.
- `rx_done`  out  1  one-cycle pulse at window end.
- `mode_sel`  out  1  to `IO_Bus.mode_sel`.
- `bus_tx_data`  out  DATA_W  to `IO_Bus.tx_data`.
- `bus_rx_data`  in  DATA_W  from `IO_Bus.demo_data`.

## Operation
- States: IDLE, TURN_TX, TX, TURN_RX, RX. `mode_sel` = 0 only in TX; all other states, and reset, keep the pins hi-Z.
- `rx_req` is accepted only when `rx_busy` = 0; it sets `rx_pend` and latches `rx_len`. Requests while busy are dropped.
- IDLE:
  - `rx_pend` → RX directly; the bus is already hi-Z, so no gap is needed.
  - Otherwise `tx_valid` → TURN_TX.
  - RX wins when both are present.
- TURN_TX: count `TURN_CYC` cycles, then go to TX with `burst_cnt` = 0.
- TX:
  - `tx_ready` = (`burst_cnt` < `MAX_BURST`).
  - On a handshake, register `bus_tx_data` ← `tx_sample` and increment `burst_cnt`.
  - Any cycle without a handshake ends the current beat. The next state is:
    - TURN_RX if `rx_pend`;
    - else TX with `burst_cnt` cleared if `burst_cnt` = `MAX_BURST` and `tx_valid` (one bubble);
    - else IDLE if `tx_valid` = 0.
- TURN_RX: `mode_sel` = 1 from state entry. Count `TURN_CYC` cycles and discard `bus_rx_data`, then go to RX.
- RX:
  - Clear `rx_pend` on entry.
  - Each RX cycle: `rx_data` ← `bus_rx_data`, `rx_valid` = 1 the next cycle.
  - After `rx_len` captures → IDLE. `rx_done` is asserted with the last `rx_valid`.
  - `rx_len` = 0: no capture; `rx_done` pulses one cycle after RX entry.
- `bus_tx_data` is cleared to 0 in every state except TX.
- `rx_busy` = `rx_pend` | TURN_RX | RX.

## Timing
- Reset (async, immediate) values:
  - `mode_sel` = 1 (pins hi-Z at once, including mid-burst);
  - `bus_tx_data` = 0;
  - `tx_ready`, `rx_valid`, `rx_done`, `rx_busy` = 0;
  - `rx_data` = 0;
  - state = IDLE, counters = 0.
- A beat accepted at edge k is on the pins from k+1 until the next accepted beat. The final beat is held at least one cycle before `mode_sel` rises.
- `mode_sel` timing:
  - falls exactly `TURN_CYC` cycles after IDLE→TURN_TX;
  - rises on the edge that leaves TX.
- RX capture latency: 1 cycle, pin to `rx_valid`. Samples are contiguous; no back-pressure on RX.
- `rx_req` arriving during TX is serviced at the next beat gap or at the `MAX_BURST` boundary, whichever comes first.
- `rx_req` arriving in the same cycle as a state change is still latched if `rx_busy` was 0.
- Counters are wide enough for `TURN_CYC`, `MAX_BURST` and 2^`RX_LEN_W`-1; no wrap is possible.

## Structure
- Package `io_bus_pkg`: `state_t` enum (IDLE, TURN_TX, TX, TURN_RX, RX), `DATA_W` default, mode constants `MODE_TX` = 0 and `MODE_RX` = 1.
- One sub-module, `io_bus_turn_timer`: a loadable down-counter with a `done` flag, shared by TURN_TX and TURN_RX.
- `io_bus_sched` and `IO_Bus` are instantiated side by side in the comsys top.

## Test plan
Bench parameters: `TURN_CYC` = 2, `MAX_BURST` = 4.
1. Reset asserted mid-TX → `mode_sel` = 1 and `bus_tx_data` = 0x00 immediately; after release, state = IDLE.
2. `tx_valid` with samples 0xA5, 0x3C, 0x0F, then `tx_valid` drops:
   - `mode_sel` = 0 two cycles after the request;
   - pins show A5/3C/0F one cycle after each accept;
   - 0x0F is held one cycle, then `mode_sel` = 1 and the scheduler returns to IDLE.
3. Continuous TX of 10 beats with no RX → bursts of 4, 4, 2 separated by one-cycle `tx_ready` bubbles; `mode_sel` stays 0 throughout.
4. `rx_req` with `rx_len` = 3 during TX beat 2:
   - TX continues to beat 4, then `mode_sel` = 1;
   - 2 discard cycles;
   - pin values 0x11, 0x22, 0x33 appear on `rx_data` with 1-cycle latency;
   - `rx_done` is asserted with 0x33.
5. `rx_req` and `tx_valid` asserted together in IDLE → RX starts the next cycle with no turnaround; TX starts only after `rx_done`.
6. Edge requests:
   - `rx_req` with `rx_len` = 0 → `rx_done` with no `rx_valid`;
   - a second `rx_req` while `rx_busy` = 1 → ignored, exactly one window captured.
